// File: rtl/simd_mem_pkg.sv
// Shared types and helpers for the SIMD memory-stage access sequencer.
package simd_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 8;

    // Bit offset of a lane within a packed vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/flopenr.sv
// Resettable register with load enable; used for per-lane load-data capture.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage flop, loads d when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vec_mem_stage.sv
// Memory-stage sequencer: splits vector/scalar loads and stores into one
// handshaked beat per lane and stalls the pipeline until the last beat.
module vec_mem_stage
    import simd_mem_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemWriteM,
    input  logic                    MemReadM,
    input  logic                    VecM,
    input  logic [ADDR_W-1:0]       AddrM,
    input  logic [LANES*LANE_W-1:0] WriteDataM,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    StallM,
    output logic [LANES*LANE_W-1:0] ReadDataW,
    output logic                    LoadDoneW
);

    localparam int VEC_W  = LANES * LANE_W;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    mem_state_t          r_state;
    mem_state_t          w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [VEC_W-1:0]    r_wdata;
    logic                r_vec;
    logic                r_op_wr;
    logic [LIDX_W-1:0]   r_lane;
    logic                w_start;
    logic                w_beat_done;
    logic                w_is_last;
    logic                w_clear;
    logic [LANE_W-1:0]   w_wlanes [LANES];

    // A store wins when both request lines are high.
    assign w_start     = (r_state == IDLE) && (MemWriteM || MemReadM);
    assign w_clear     = w_start && !MemWriteM;
    assign w_beat_done = (r_state == ACCESS) && mem_ack;
    assign w_is_last   = r_vec ? (r_lane == LAST_LANE) : (r_lane == {LIDX_W{1'b0}});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = ACCESS;
                else         w_next = IDLE;
            end
            ACCESS: begin
                if (w_beat_done && w_is_last) w_next = DONE;
                else                          w_next = ACCESS;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latches and lane counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base  <= {ADDR_W{1'b0}};
            r_wdata <= {VEC_W{1'b0}};
            r_vec   <= 1'b0;
            r_op_wr <= 1'b0;
            r_lane  <= {LIDX_W{1'b0}};
        end else if (w_start) begin
            r_base  <= AddrM;
            r_wdata <= WriteDataM;
            r_vec   <= VecM;
            r_op_wr <= MemWriteM;
            r_lane  <= {LIDX_W{1'b0}};
        end else if (w_beat_done && !w_is_last) begin
            r_lane  <= r_lane + LIDX_W'(1);
        end
    end

    // Per-lane store slices and load capture; a new load first zeroes every lane.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic w_lane_en;
        assign w_wlanes[i] = r_wdata[lane_lsb(i, LANE_W) +: LANE_W];
        assign w_lane_en   = w_clear || (w_beat_done && !r_op_wr && (r_lane == LIDX_W'(i)));

        flopenr #(.WIDTH(LANE_W)) u_rd_lane (
            .clk   (clk),
            .reset (reset),
            .en    (w_lane_en),
            .d     (w_clear ? {LANE_W{1'b0}} : mem_rdata),
            .q     (ReadDataW[lane_lsb(i, LANE_W) +: LANE_W])
        );
    end

    // Output decode; everything except the IDLE stall comes from registers.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {LANE_W{1'b0}};
        StallM    = 1'b0;
        LoadDoneW = 1'b0;
        case (r_state)
            IDLE: StallM = w_start;
            ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = r_op_wr;
                mem_addr  = r_base + ADDR_W'(r_lane);
                mem_wdata = w_wlanes[r_lane];
                StallM    = 1'b1;
            end
            DONE:    LoadDoneW = !r_op_wr;
            default: StallM = 1'b0;
        endcase
    end

endmodule

// File: doc/vec_mem_stage.md
# vec_mem_stage

Memory-stage access sequencer for the SIMD pipeline, directly downstream of the execute-stage condition unit. It consumes the condition-gated MemWriteM/RegWriteM-side controls plus the ALU address and vector store data, and splits each vector load/store into per-lane accesses on a narrow, handshaked data-memory port. It stalls the pipeline until all lanes complete and presents the assembled load vector to writeback.

## Interface
Parameters:
- LANES, 4, number of SIMD lanes per vector
- LANE_W, 8, bits per lane; one lane per memory beat
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  single pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- MemWriteM  in  1  store request, already gated by CondEx
- MemReadM  in  1  load request, already gated by CondEx
- VecM  in  1  1 = vector op (all LANES), 0 = scalar (lane 0 only)
- AddrM  in  ADDR_W  base byte address from ALU
- WriteDataM  in  LANES*LANE_W  store vector; lane i = bits [i*LANE_W +: LANE_W]
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  LANE_W  beat write data
- mem_ack  in  1  beat accepted/completed; may be high in the same cycle as mem_req
- mem_rdata  in  LANE_W  read data, valid when mem_ack=1 on a read beat
- StallM  out  1  holds fetch/decode/execute and EX/MEM register
- ReadDataW  out  LANES*LANE_W  assembled load vector
- LoadDoneW  out  1  one-cycle pulse: ReadDataW updated

## Operation
- States: IDLE, ACCESS, DONE (encoding in package).
- IDLE: if MemWriteM|MemReadM, latch AddrM, WriteDataM, VecM, op (write if MemWriteM), lane=0; on a load, clear ReadDataW to 0; go ACCESS. StallM=1 combinationally in that cycle.
- Both MemWriteM and MemReadM high: treated as a store; the read is dropped.
- ACCESS: mem_req=1, mem_we=op, mem_addr=base+lane (mod 2^ADDR_W, wraps silently), mem_wdata=stored lane. Without mem_ack: hold all outputs stable. With mem_ack: on a load, write mem_rdata into lane slot; if lane==last (LANES-1 vector, 0 scalar) go DONE, else lane+1.
- DONE: StallM=0, mem_req=0; LoadDoneW=1 if op was a load; inputs ignored; next state IDLE.
- StallM=1 in ACCESS and in IDLE with a request, else 0.
- ReadDataW holds its value between loads; stores never change it.
- Reset (any state, including mid-ACCESS): state IDLE, lane 0, all latches 0, access abandoned; mem_req drops immediately.

## Timing
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, StallM 0, ReadDataW 0, LoadDoneW 0.
- Zero-wait memory (mem_ack tied high): vector op stalls LANES+1 cycles (1 IDLE + LANES ACCESS), DONE on the following cycle; scalar stalls 2 cycles.
- Each wait cycle (mem_ack=0 in ACCESS) adds exactly one stall cycle.
- LoadDoneW and the new ReadDataW appear together in the DONE cycle.
- Back-to-back requests: the next op is accepted in the IDLE cycle after DONE; no bubble beyond DONE.

## Structure
- Package simd_mem_pkg: state enum (IDLE/ACCESS/DONE), default LANES and LANE_W constants, lane-slice helper function.
- Lane read-data capture uses the existing flopenr register, one instance per lane with enable = load & ack & (lane==i). All other logic sits in vec_mem_stage.

## Test plan
- Vector store, AddrM=0x100, WriteDataM=0xDDCCBBAA, ack tied high -> beats 0x100/AA, 0x101/BB, 0x102/CC, 0x103/DD with mem_we=1; StallM high 5 cycles; LoadDoneW stays 0.
- Vector load from 0x200, mem_rdata 11,22,33,44 -> ReadDataW=0x44332211, LoadDoneW pulses once in DONE.
- Scalar load, AddrM=0x40, rdata 0x5A, 2 wait cycles -> single beat held stable 3 cycles, ReadDataW=0x0000005A, StallM high 4 cycles.
- Vector store at AddrM=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset asserted after lane 1 ack of a load -> next cycle all outputs at reset values, state IDLE; following load completes normally.
- MemWriteM=MemReadM=1 -> store performed, ReadDataW unchanged, no LoadDoneW.
